// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - register file geometry and shared index/data types
package regfile_pkg;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_fwd_mux.sv
// rtl/regfile_fwd_mux.sv - per-operand select: disabled zero, forwarded writeback, or base data
// REGFILE_ZERO_REG_EN: index 0 reads as zero and is never forwarded.
module regfile_fwd_mux #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic              op_en,
   input  logic [ADDR_W-1:0] op_rs,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [DATA_W-1:0] base_data,
   output logic [DATA_W-1:0] op_data
);
   import regfile_pkg::*;

   always_comb begin
      op_data = base_data;
      if (!op_en) begin
         op_data = '0;
      end
`ifdef REGFILE_ZERO_REG_EN
      else if (op_rs == '0) begin
         op_data = '0;
      end
`endif
      else if (wb_valid && (wb_reg == op_rs)) begin
         op_data = wb_data;
      end
   end

endmodule

// File: rtl/regfile_operand_fetch.sv
// rtl/regfile_operand_fetch.sv - two-stage operand fetch with writeback forwarding
// REGFILE_ZERO_REG_EN: hardwire register index 0 to zero.
module regfile_operand_fetch #(
   parameter int TAG_W  = 4,
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_rs1,
   input  logic [ADDR_W-1:0] in_rs2,
   input  logic              in_rs1_en,
   input  logic              in_rs2_en,
   input  logic [TAG_W-1:0]  in_tag,
   output logic [ADDR_W-1:0] rf_read_reg1,
   output logic [ADDR_W-1:0] rf_read_reg2,
   output logic              rf_read_en1,
   output logic              rf_read_en2,
   input  logic [DATA_W-1:0] rf_read_data1,
   input  logic [DATA_W-1:0] rf_read_data2,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   output logic              rf_write_en,
   output logic [ADDR_W-1:0] rf_write_reg,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_op1,
   output logic [DATA_W-1:0] out_op2,
   output logic [TAG_W-1:0]  out_tag
);
   import regfile_pkg::*;

   logic              s1_valid_q, s1_valid_d;
   logic [ADDR_W-1:0] s1_rs1_q, s1_rs1_d, s1_rs2_q, s1_rs2_d;
   logic              s1_en1_q, s1_en1_d, s1_en2_q, s1_en2_d;
   logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
   logic              s1_byp1_q, s1_byp1_d, s1_byp2_q, s1_byp2_d;
   logic [DATA_W-1:0] s1_byp_data1_q, s1_byp_data1_d, s1_byp_data2_q, s1_byp_data2_d;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_op1_q, out_op1_d, out_op2_q, out_op2_d;
   logic [TAG_W-1:0]  out_tag_q, out_tag_d;
   logic [ADDR_W-1:0] out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
   logic              out_en1_q, out_en1_d, out_en2_q, out_en2_d;

   logic              s1_move, fire;
   logic              rd_ok1, rd_ok2, wr_ok;
   logic [DATA_W-1:0] s1_base1, s1_base2, s1_op1, s1_op2, hold_op1, hold_op2;

`ifdef REGFILE_ZERO_REG_EN
   assign rd_ok1 = (in_rs1 != '0);
   assign rd_ok2 = (in_rs2 != '0);
   assign wr_ok  = (wb_reg != '0);
`else
   assign rd_ok1 = 1'b1;
   assign rd_ok2 = 1'b1;
   assign wr_ok  = 1'b1;
`endif

   assign rf_write_en   = wb_valid && wr_ok;
   assign rf_write_reg  = wb_reg;
   assign rf_write_data = wb_data;

   assign s1_move  = s1_valid_q && (!out_valid_q || out_ready);
   assign in_ready = rst_n && (!s1_valid_q || s1_move);
   assign fire     = in_valid && in_ready;

   assign rf_read_reg1 = in_rs1;
   assign rf_read_reg2 = in_rs2;
   assign rf_read_en1  = fire && in_rs1_en && rd_ok1;
   assign rf_read_en2  = fire && in_rs2_en && rd_ok2;

   // The RF read register only reflects writes up to the accept cycle; writes seen
   // while S1 is stalled are captured here so they are not lost before the move.
   assign s1_base1 = s1_byp1_q ? s1_byp_data1_q : rf_read_data1;
   assign s1_base2 = s1_byp2_q ? s1_byp_data2_q : rf_read_data2;

   regfile_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_s1_mux1 (
      .op_en(s1_en1_q), .op_rs(s1_rs1_q), .wb_valid(wb_valid), .wb_reg(wb_reg),
      .wb_data(wb_data), .base_data(s1_base1), .op_data(s1_op1)
   );
   regfile_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_s1_mux2 (
      .op_en(s1_en2_q), .op_rs(s1_rs2_q), .wb_valid(wb_valid), .wb_reg(wb_reg),
      .wb_data(wb_data), .base_data(s1_base2), .op_data(s1_op2)
   );
   regfile_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_out_mux1 (
      .op_en(out_en1_q), .op_rs(out_rs1_q), .wb_valid(wb_valid), .wb_reg(wb_reg),
      .wb_data(wb_data), .base_data(out_op1_q), .op_data(hold_op1)
   );
   regfile_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_out_mux2 (
      .op_en(out_en2_q), .op_rs(out_rs2_q), .wb_valid(wb_valid), .wb_reg(wb_reg),
      .wb_data(wb_data), .base_data(out_op2_q), .op_data(hold_op2)
   );

   always_comb begin
      s1_valid_d     = s1_valid_q;
      s1_rs1_d       = s1_rs1_q;
      s1_rs2_d       = s1_rs2_q;
      s1_en1_d       = s1_en1_q;
      s1_en2_d       = s1_en2_q;
      s1_tag_d       = s1_tag_q;
      s1_byp1_d      = s1_byp1_q;
      s1_byp2_d      = s1_byp2_q;
      s1_byp_data1_d = s1_byp_data1_q;
      s1_byp_data2_d = s1_byp_data2_q;
      if (fire) begin
         s1_valid_d = 1'b1;
         s1_rs1_d   = in_rs1;
         s1_rs2_d   = in_rs2;
         s1_en1_d   = in_rs1_en;
         s1_en2_d   = in_rs2_en;
         s1_tag_d   = in_tag;
         s1_byp1_d  = 1'b0;
         s1_byp2_d  = 1'b0;
      end else if (s1_move) begin
         s1_valid_d = 1'b0;
      end else if (s1_valid_q) begin
         s1_byp1_d      = 1'b1;
         s1_byp2_d      = 1'b1;
         s1_byp_data1_d = s1_op1;
         s1_byp_data2_d = s1_op2;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_op1_d   = out_op1_q;
      out_op2_d   = out_op2_q;
      out_tag_d   = out_tag_q;
      out_rs1_d   = out_rs1_q;
      out_rs2_d   = out_rs2_q;
      out_en1_d   = out_en1_q;
      out_en2_d   = out_en2_q;
      if (s1_move) begin
         out_valid_d = 1'b1;
         out_op1_d   = s1_op1;
         out_op2_d   = s1_op2;
         out_tag_d   = s1_tag_q;
         out_rs1_d   = s1_rs1_q;
         out_rs2_d   = s1_rs2_q;
         out_en1_d   = s1_en1_q;
         out_en2_d   = s1_en2_q;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end else if (out_valid_q) begin
         out_op1_d = hold_op1;
         out_op2_d = hold_op2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q     <= 1'b0;
         s1_rs1_q       <= '0;
         s1_rs2_q       <= '0;
         s1_en1_q       <= 1'b0;
         s1_en2_q       <= 1'b0;
         s1_tag_q       <= '0;
         s1_byp1_q      <= 1'b0;
         s1_byp2_q      <= 1'b0;
         s1_byp_data1_q <= '0;
         s1_byp_data2_q <= '0;
         out_valid_q    <= 1'b0;
         out_op1_q      <= '0;
         out_op2_q      <= '0;
         out_tag_q      <= '0;
         out_rs1_q      <= '0;
         out_rs2_q      <= '0;
         out_en1_q      <= 1'b0;
         out_en2_q      <= 1'b0;
      end else begin
         s1_valid_q     <= s1_valid_d;
         s1_rs1_q       <= s1_rs1_d;
         s1_rs2_q       <= s1_rs2_d;
         s1_en1_q       <= s1_en1_d;
         s1_en2_q       <= s1_en2_d;
         s1_tag_q       <= s1_tag_d;
         s1_byp1_q      <= s1_byp1_d;
         s1_byp2_q      <= s1_byp2_d;
         s1_byp_data1_q <= s1_byp_data1_d;
         s1_byp_data2_q <= s1_byp_data2_d;
         out_valid_q    <= out_valid_d;
         out_op1_q      <= out_op1_d;
         out_op2_q      <= out_op2_d;
         out_tag_q      <= out_tag_d;
         out_rs1_q      <= out_rs1_d;
         out_rs2_q      <= out_rs2_d;
         out_en1_q      <= out_en1_d;
         out_en2_q      <= out_en2_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_op1   = out_op1_q;
   assign out_op2   = out_op2_q;
   assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// tb/tb_regfile_operand_fetch.sv - scoreboard bench for regfile_operand_fetch (honours REGFILE_ZERO_REG_EN)
module tb_regfile_operand_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic [4:0]  in_rs1 = '0, in_rs2 = '0;
   logic        in_rs1_en = 1'b0, in_rs2_en = 1'b0;
   logic [3:0]  in_tag = '0;
   logic [4:0]  rf_read_reg1, rf_read_reg2;
   logic        rf_read_en1, rf_read_en2;
   logic [31:0] rf_read_data1 = '0, rf_read_data2 = '0;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_reg = '0;
   logic [31:0] wb_data = '0;
   logic        rf_write_en;
   logic [4:0]  rf_write_reg;
   logic [31:0] rf_write_data;
   logic        out_valid, out_ready = 1'b0;
   logic [31:0] out_op1, out_op2;
   logic [3:0]  out_tag;

   always #5 clk = ~clk;

   regfile_operand_fetch #(.TAG_W(4), .DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en),
      .in_tag(in_tag),
      .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
      .rf_read_en1(rf_read_en1), .rf_read_en2(rf_read_en2),
      .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
      .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op1(out_op1), .out_op2(out_op2), .out_tag(out_tag)
   );

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       en1;
      logic       en2;
      logic [3:0] tag;
   } req_t;

   req_t        sb[$];
   req_t        req, head;
   logic [31:0] rf_mem [32];
   logic [31:0] arch [32];
   int          n_checks = 0;
   int          n_pass = 0;
   bit          m_s1 = 1'b0, m_out = 1'b0, rdy_exp, fire_exp, mv_exp;
   bit          rnd_done;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic bit nz(input logic [4:0] r);
`ifdef REGFILE_ZERO_REG_EN
      return r != 5'd0;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [31:0] exp_op(input logic en, input logic [4:0] rs);
      if (!en || !nz(rs)) return 32'h0;
      return arch[rs];
   endfunction

   // Register file model: writes at negedge, registered reads at posedge.
   always @(negedge clk) if (rf_write_en) rf_mem[rf_write_reg] = rf_write_data;
   always @(posedge clk) begin
      if (rf_read_en1) rf_read_data1 <= rf_mem[rf_read_reg1];
      if (rf_read_en2) rf_read_data2 <= rf_mem[rf_read_reg2];
   end

   // Operands must equal the architectural state as of writes before the handshake cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         m_s1  = 1'b0;
         m_out = 1'b0;
      end else begin
         rdy_exp  = !(m_s1 && m_out && !out_ready);
         fire_exp = in_valid && rdy_exp;
         chk("in_ready", in_ready, rdy_exp);
         chk("out_valid", out_valid, m_out);
         chk("rd_en1", rf_read_en1, fire_exp && in_rs1_en && nz(in_rs1));
         chk("rd_en2", rf_read_en2, fire_exp && in_rs2_en && nz(in_rs2));
         if (fire_exp) begin
            chk("rd_reg1", rf_read_reg1, in_rs1);
            chk("rd_reg2", rf_read_reg2, in_rs2);
         end
         chk("wr_en", rf_write_en, wb_valid && nz(wb_reg));
         if (wb_valid) begin
            chk("wr_reg", rf_write_reg, wb_reg);
            chk("wr_data", rf_write_data, wb_data);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               head = sb.pop_front();
               chk("sb_tag", out_tag, head.tag);
               chk("sb_op1", out_op1, exp_op(head.en1, head.rs1));
               chk("sb_op2", out_op2, exp_op(head.en2, head.rs2));
            end
         end
         mv_exp = m_s1 && (!m_out || out_ready);
         m_out  = mv_exp || (m_out && !out_ready);
         m_s1   = fire_exp || (m_s1 && !mv_exp);
         if (in_valid && in_ready) begin
            req.rs1 = in_rs1; req.rs2 = in_rs2;
            req.en1 = in_rs1_en; req.en2 = in_rs2_en;
            req.tag = in_tag;
            sb.push_back(req);
         end
         if (wb_valid && nz(wb_reg)) arch[wb_reg] = wb_data;
      end
   end

   task automatic send(input logic [4:0] r1, input logic [4:0] r2, input logic e1,
                       input logic e2, input logic [3:0] t);
      bit acc = 1'b0;
      in_rs1 = r1; in_rs2 = r2; in_rs1_en = e1; in_rs2_en = e2; in_tag = t;
      in_valid = 1'b1;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_out();
      bit got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         if (out_valid) got = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!got) chk("out_timeout", 0, 1);
   endtask

   task automatic wb_pulse(input logic [4:0] r, input logic [31:0] d);
      wb_valid = 1'b1; wb_reg = r; wb_data = d;
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf_mem[i] = 32'hC0DE_0000 | 32'(i);
         arch[i]   = 32'hC0DE_0000 | 32'(i);
      end
      rf_mem[5] = 32'h1234_5678; arch[5] = 32'h1234_5678;
      rf_mem[9] = 32'hDEAD_BEEF; arch[9] = 32'hDEAD_BEEF;
      rf_mem[7] = 32'h1;         arch[7] = 32'h1;
      rf_mem[3] = 32'h10;        arch[3] = 32'h10;

      in_valid = 1'b1; in_rs1 = 5'd5; in_rs1_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_rd_en1", rf_read_en1, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_op1", out_op1, 0);
      chk("rst_op2", out_op2, 0);
      chk("rst_tag", out_tag, 0);
      in_valid = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      out_ready = 1'b1;
      in_rs1 = 5'd5; in_rs2 = 5'd9; in_rs1_en = 1'b1; in_rs2_en = 1'b1; in_tag = 4'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("basic_lat1", out_valid, 0);
      @(posedge clk);
      #1;
      chk("basic_valid", out_valid, 1);
      chk("basic_op1", out_op1, 32'h1234_5678);
      chk("basic_op2", out_op2, 32'hDEAD_BEEF);
      chk("basic_tag", out_tag, 4'd3);
      @(posedge clk);
      #1;

      send(5'd7, 5'd0, 1'b1, 1'b0, 4'd1);
      wb_pulse(5'd7, 32'hAA);
      chk("fwd_s1_valid", out_valid, 1);
      chk("fwd_s1_op1", out_op1, 32'hAA);
      chk("fwd_s1_op2", out_op2, 0);
      @(posedge clk);
      #1;
      wb_pulse(5'd7, 32'h1);
      wb_valid = 1'b1; wb_reg = 5'd7; wb_data = 32'hAA;
      send(5'd7, 5'd0, 1'b1, 1'b0, 4'd2);
      wb_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("fwd_acc_op1", out_op1, 32'hAA);
      @(posedge clk);
      #1;

      out_ready = 1'b0;
      send(5'd0, 5'd3, 1'b0, 1'b1, 4'd5);
      wait_out();
      chk("stall_op2_old", out_op2, 32'h10);
      chk("stall_op1", out_op1, 0);
      wb_pulse(5'd3, 32'h20);
      chk("stall_op2_new", out_op2, 32'h20);
      chk("stall_valid", out_valid, 1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_drained", out_valid, 0);

      wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'hFF;
      #1;
`ifdef REGFILE_ZERO_REG_EN
      chk("zero_wr_en", rf_write_en, 0);
`else
      chk("zero_wr_en", rf_write_en, 1);
`endif
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
      send(5'd0, 5'd0, 1'b1, 1'b0, 4'd2);
      @(posedge clk);
      #1;
`ifdef REGFILE_ZERO_REG_EN
      chk("zero_op1", out_op1, 32'h0);
`else
      chk("zero_op1", out_op1, 32'hFF);
`endif
      @(posedge clk);
      #1;

      fork
         begin
            out_ready = 1'b1;
            @(posedge clk); #1; out_ready = 1'b0;
            @(posedge clk); #1; out_ready = 1'b1;
            @(posedge clk); #1; out_ready = 1'b1;
         end
         begin
            send(5'd5, 5'd9, 1'b1, 1'b1, 4'd8);
            send(5'd9, 5'd3, 1'b1, 1'b1, 4'd9);
            send(5'd7, 5'd5, 1'b1, 1'b0, 4'd10);
            send(5'd3, 5'd7, 1'b0, 1'b1, 4'd11);
         end
      join
      out_ready = 1'b1;
      for (int k = 0; k < 20 && (sb.size() != 0 || out_valid); k++) begin
         @(posedge clk);
         #1;
      end
      chk("b2b_drained", sb.size(), 0);

      out_ready = 1'b0;
      send(5'd5, 5'd9, 1'b1, 1'b1, 4'hA);
      send(5'd3, 5'd7, 1'b1, 1'b1, 4'hB);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_op1", out_op1, 0);
      chk("mid_rst_op2", out_op2, 0);
      chk("mid_rst_tag", out_tag, 0);
      in_valid = 1'b1; in_rs1 = 5'd5; in_rs1_en = 1'b1;
      #1;
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_rd_en1", rf_read_en1, 0);
      in_valid = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(5'd9, 5'd5, 1'b1, 1'b1, 4'd6);
      wait_out();
      chk("post_rst_tag", out_tag, 4'd6);
      chk("post_rst_op1", out_op1, exp_op(1'b1, 5'd9));
      chk("post_rst_op2", out_op2, exp_op(1'b1, 5'd5));
      @(posedge clk);
      #1;

      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, 4'(i));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               wb_valid = $urandom_range(0, 1) != 0;
               wb_reg   = 5'($urandom_range(0, 7));
               wb_data  = $urandom;
               @(posedge clk);
               #1;
            end
            wb_valid = 1'b0;
         end
         begin
            while (!rnd_done) begin
               out_ready = $urandom_range(0, 2) != 0;
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      for (int k = 0; k < 40 && (sb.size() != 0 || out_valid); k++) begin
         @(posedge clk);
         #1;
      end
      chk("rnd_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
